// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef enum logic {
        REDIR_PCREL = 1'b0,
        REDIR_REG   = 1'b1
    } redirect_type_t;

    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/pc_target_calc.sv
// Branch target computation: PC-relative word offset or absolute register target.
module pc_target_calc
    import fetch_pkg::*;
(
    input  logic        redirect_type,
    input  logic [63:0] redirect_pc,
    input  logic [63:0] redirect_offset,
    input  logic [63:0] redirect_reg,
    output logic [63:0] target,
    output logic        misaligned
);

    always_comb begin
        target = 64'h0;
        if (redirect_type_t'(redirect_type) == REDIR_REG) begin
            target = redirect_reg;
        end else begin
            // Offset counts instructions, so scale to bytes; the sum wraps mod 2^64.
            target = redirect_pc + (redirect_offset << 2);
        end
        misaligned = |target[1:0];
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, issues instruction fetches and holds one fetched instruction for decode.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        redirect,
    input  logic        redirect_type,
    input  logic [63:0] redirect_pc,
    input  logic [63:0] redirect_offset,
    input  logic [63:0] redirect_reg,
    input  logic        halt,
    output logic        halted,
    output logic        fault
);

    fetch_state_t state_q;
    logic [63:0]  pc_q;
    logic [31:0]  instr_q;
    logic [63:0]  instr_pc_q;
    logic         instr_valid_q;
    logic         halted_q;
    logic         fault_q;

    logic [63:0]  target;
    logic         misaligned;

    pc_target_calc u_target (
        .redirect_type   (redirect_type),
        .redirect_pc     (redirect_pc),
        .redirect_offset (redirect_offset),
        .redirect_reg    (redirect_reg),
        .target          (target),
        .misaligned      (misaligned)
    );

    // No path from imem_ack: the request depends only on state and stall.
    assign imem_req    = (state_q == FETCH) && !(instr_valid_q && stall);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;
    assign fault       = fault_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_pc_q    <= 64'h0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else if (state_q == FETCH) begin
            if (halt) begin
                state_q       <= HALTED;
                instr_valid_q <= 1'b0;
                halted_q      <= 1'b1;
            end else if (redirect && misaligned) begin
                state_q       <= HALTED;
                instr_valid_q <= 1'b0;
                halted_q      <= 1'b1;
                fault_q       <= 1'b1;
            end else if (redirect) begin
                pc_q          <= target;
                instr_valid_q <= 1'b0;
            end else if (imem_ack && imem_req) begin
                // Refill in the same cycle as consumption so there is no bubble.
                instr_q       <= imem_rdata;
                instr_pc_q    <= pc_q;
                instr_valid_q <= 1'b1;
                pc_q          <= pc_q + 64'(INSTR_BYTES);
            end else if (instr_valid_q && !stall) begin
                instr_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: fetches are scored by a queue, consumed instructions checked by a monitor.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        stall;
    logic        redirect;
    logic        redirect_type;
    logic [63:0] redirect_pc;
    logic [63:0] redirect_offset;
    logic [63:0] redirect_reg;
    logic        halt;
    logic        halted;
    logic        fault;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] word;
        logic [63:0] pc;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_sequencer #(.RESET_PC(64'h0)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_type   (redirect_type),
        .redirect_pc     (redirect_pc),
        .redirect_offset (redirect_offset),
        .redirect_reg    (redirect_reg),
        .halt            (halt),
        .halted          (halted),
        .fault           (fault)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every consumed instruction must match the oldest accepted fetch.
    always @(negedge clk) begin
        #2;
        if (reset === 1'b0 && instr_valid === 1'b1 && stall === 1'b0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_instr: got pc %h, required none", instr_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("instr", {32'h0, instr}, {32'h0, e.word});
                chk("instr_pc", instr_pc, e.pc);
            end
        end
    end

    // One plain cycle: drive ack/stall, check request and address, record accepted fetches.
    task automatic cyc(input logic a, input logic s, input logic exp_req,
                       input logic [63:0] exp_addr, input logic acc);
        @(negedge clk);
        imem_ack = a;
        stall    = s;
        redirect = 1'b0;
        halt     = 1'b0;
        #1;
        chk("imem_req", {63'h0, imem_req}, {63'h0, exp_req});
        chk("imem_addr", imem_addr, exp_addr);
        if (acc) exp_q.push_back('{word: mem_word(exp_addr), pc: exp_addr});
    endtask

    task automatic redir(input logic t, input logic [63:0] rpc, input logic [63:0] off,
                         input logic [63:0] rg, input logic a, input logic h,
                         input logic exp_req, input logic [63:0] exp_addr);
        @(negedge clk);
        imem_ack        = a;
        stall           = 1'b0;
        redirect        = 1'b1;
        redirect_type   = t;
        redirect_pc     = rpc;
        redirect_offset = off;
        redirect_reg    = rg;
        halt            = h;
        #1;
        chk("redir_req", {63'h0, imem_req}, {63'h0, exp_req});
        chk("redir_addr", imem_addr, exp_addr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        imem_ack = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        halt     = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_valid", {63'h0, instr_valid}, 64'h0);
        chk("rst_halted", {63'h0, halted}, 64'h0);
        chk("rst_fault", {63'h0, fault}, 64'h0);
        chk("rst_addr", imem_addr, 64'h0);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        imem_ack        = 1'b0;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_type   = 1'b0;
        redirect_pc     = 64'h0;
        redirect_offset = 64'h0;
        redirect_reg    = 64'h0;
        halt            = 1'b0;
        do_reset();
        chk("rst_instr", {32'h0, instr}, 64'h0);
        chk("rst_instr_pc", instr_pc, 64'h0);

        // Sequential fetch, one per cycle.
        cyc(1'b1, 1'b0, 1'b1, 64'd0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 64'd4, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 64'd8, 1'b1);
        // Stall with instr_pc=8: request withdrawn, an ack is ignored, state held.
        cyc(1'b0, 1'b1, 1'b0, 64'd12, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 64'd12, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 64'd12, 1'b0);
        chk("stall_instr_pc", instr_pc, 64'd8);
        chk("stall_instr", {32'h0, instr}, {32'h0, mem_word(64'd8)});
        cyc(1'b1, 1'b0, 1'b1, 64'd12, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 64'd16, 1'b0);

        // PC-relative redirect: 0x20 + (-3 << 2) = 0x14; same-cycle ack dropped.
        redir(1'b0, 64'h20, -64'sd3, 64'h0, 1'b1, 1'b0, 1'b1, 64'd16);
        cyc(1'b1, 1'b0, 1'b1, 64'h14, 1'b1);
        chk("pcrel_valid_after", {63'h0, instr_valid}, 64'h0);
        cyc(1'b0, 1'b0, 1'b1, 64'h18, 1'b0);

        // Register redirect to the top word, then PC wraps to 0.
        redir(1'b1, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b1, 64'h18);
        cyc(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 64'h0, 1'b0);

        // Slow memory: address stable until the ack, then advances once.
        cyc(1'b0, 1'b0, 1'b1, 64'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 64'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 64'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 64'h4, 1'b0);

        // Misaligned register target with a buffered instruction: halts with fault.
        cyc(1'b1, 1'b0, 1'b1, 64'h4, 1'b1);
        redir(1'b1, 64'h0, 64'h0, 64'h1002, 1'b1, 1'b0, 1'b1, 64'h8);
        cyc(1'b0, 1'b0, 1'b0, 64'h8, 1'b0);
        chk("mis_halted", {63'h0, halted}, 64'h1);
        chk("mis_fault", {63'h0, fault}, 64'h1);
        chk("mis_valid", {63'h0, instr_valid}, 64'h0);
        // Later redirects and acks are ignored while halted.
        redir(1'b1, 64'h0, 64'h0, 64'h100, 1'b1, 1'b0, 1'b0, 64'h8);
        cyc(1'b1, 1'b0, 1'b0, 64'h8, 1'b0);
        chk("halted_stays", {63'h0, halted}, 64'h1);

        // Reset out of HALTED.
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 64'h0, 1'b0);

        // Halt wins over a misaligned redirect in the same cycle: no fault.
        redir(1'b1, 64'h0, 64'h0, 64'h1002, 1'b0, 1'b1, 1'b1, 64'h0);
        cyc(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        chk("halt_halted", {63'h0, halted}, 64'h1);
        chk("halt_fault", {63'h0, fault}, 64'h0);

        do_reset();
        cyc(1'b1, 1'b0, 1'b1, 64'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 64'h4, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 64'h4, 1'b0);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
